shift_sequencer: RTL
====================

# shift_sequencer

Command sequencer that drives the 8-bit universal shift register (hold/load/shift-left/shift-right datapath with IL/IR serial inputs). It accepts one command at a time over a valid/ready handshake and decodes it into a per-cycle stream of select codes, parallel-load data and serial fill bits. Fill bits come from the register's fed-back output, which gives logical, arithmetic and rotate shifts of 0–7 positions. A `done` pulse marks the cycle in which the register holds the result.

## Interface
- `DATA_W`, 8: register width. Fixed at 8 to match the shift register.
- `AMT_W`, 3: shift-amount width. Covers amounts 0..7.
- `clk` in 1: rising-edge clock, shared with the shift register.
- `reset` in 1: asynchronous, active-high; shared with the shift register.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: high only in IDLE; a command is accepted when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_op` in 3: operation code.
  - 000 LOAD, 001 SLL, 010 SRL, 011 SRA, 100 ROL, 101 ROR.
  - 110 and 111 are illegal.
- `cmd_data` in 8: load value; used by LOAD only.
- `cmd_amt` in 3: shift count 0..7; ignored by LOAD.
- `sh_q` in 8: shift register output, fed back.
- `sh_in` out 8: parallel data to the register.
- `sh_s` out 2: register select code.
  - 00 hold, 01 load.
  - 10 shift toward MSB, IR enters bit0.
  - 11 shift toward LSB, IL enters bit7.
- `sh_il` out 1: serial bit into bit7 during `sh_s`=11.
- `sh_ir` out 1: serial bit into bit0 during `sh_s`=10.
- `busy` out 1: high in LOAD, SHIFT and DONE.
- `done` out 1: one-cycle pulse; `sh_q` holds the result during this cycle.
- `err` out 1: one-cycle pulse coincident with `done` for an illegal op.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- On accept:
  - `cmd_op`, `cmd_data` and `cmd_amt` are registered.
  - A down-counter is loaded with `cmd_amt`.
- Transitions out of IDLE on accept:
  - LOAD op → LOAD.
  - Legal shift op with amt ≠ 0 → SHIFT.
  - Shift op with amt = 0 → DONE.
  - Illegal op → DONE with `err` flagged.
- LOAD state, 1 cycle: `sh_s`=01 and `sh_in`=latched data; then → DONE.
- SHIFT state:
  - `sh_s`=10 for SLL/ROL and 11 for SRL/SRA/ROR.
  - The counter decrements each cycle; when it reaches 1 the next state is DONE.
  - The state therefore lasts exactly amt cycles.
- Fill bits are combinational from `sh_q` during SHIFT:
  - SLL: `sh_ir`=0.
  - SRL: `sh_il`=0.
  - SRA: `sh_il`=`sh_q[7]`.
  - ROL: `sh_ir`=`sh_q[7]`.
  - ROR: `sh_il`=`sh_q[0]`.
  - The unused fill bit is 0.
- DONE state, 1 cycle: `sh_s`=00, `done`=1, `err`=1 if the op was illegal; then → IDLE.
- `sh_s`=00 in IDLE and DONE; the register holds its value.
- Shift ops operate on the current register contents; only LOAD changes them from `cmd_data`.
- `sh_in` = latched data in every state; it is 0 after reset. Its value matters only when `sh_s`=01.
- While `busy` is high, `cmd_valid` is ignored and the command is not consumed. The upstream side must hold the command until `cmd_ready`.

## Timing
- Accept edge = T.
- LOAD: `sh_s`=01 in cycle T+1; `done` in cycle T+2 with `sh_q`=data.
- Shift by N (1..7): `sh_s` active in cycles T+1..T+N; `done` in cycle T+N+1.
- Amt 0 or illegal op: `done` (and `err`) in cycle T+1; `sh_s` stays 00 throughout.
- `cmd_ready` returns high the cycle after DONE, so the next accept is earliest at the end of that cycle. Minimum spacing:
  - LOAD: 3 cycles.
  - Shift by N: N+2 cycles.
- Reset, asserted at any time:
  - State goes to IDLE immediately; the command in flight is dropped with no `done`.
  - `sh_s`=00, `sh_in`=0, `sh_il`=`sh_ir`=0.
  - `busy`=`done`=`err`=0; counter = 0.
  - `cmd_ready`=0 while reset is high, 1 from the first cycle after release.
- The shift register resets to 0 in parallel, so `sh_q`=0x00 after reset.

## Test plan
- Reset, then LOAD 0xA5: `sh_s`=01 for exactly one cycle; `done` at T+2; `sh_q`=0xA5; `busy` high for cycles T+1..T+2.
- From 0xA5, SLL amt 3: `sh_s`=10 for 3 cycles with `sh_ir`=0; `done` at T+4; `sh_q`=0x28. Then ROL amt 3 from a freshly loaded 0xA5 → 0x2D.
- From 0x96: SRA amt 2 → 0xE5 (`sh_il` tracks `sh_q[7]`=1). Reload 0x96 and run SRL amt 2 → 0x25. From 0x01, ROR amt 1 → 0x80.
- From 0x3C:
  - SLL amt 0 → `done` at T+1, `sh_s` never leaves 00, `sh_q`=0x3C.
  - `cmd_op`=110 → `done` and `err` at T+1, `sh_q`=0x3C.
- Hold `cmd_valid` high with a second LOAD 0xFF during a 5-cycle SHIFT: not accepted until `cmd_ready` returns after DONE; it is then executed exactly once.
- Assert `reset` asynchronously mid-cycle during the 2nd cycle of a 5-cycle SRL:
  - `sh_s`=00 and `busy`=0 immediately; no `done` pulse; `sh_q`=0x00.
  - After release, LOAD 0x5A completes normally at T+2.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// Command handshake and shift-register drive bundle for shift_sequencer.
// slave = sequencer side, master = command source / register side.
interface shift_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int AMT_W  = 3
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic [AMT_W-1:0]  cmd_amt;
  logic [DATA_W-1:0] sh_q;
  logic [DATA_W-1:0] sh_in;
  logic [1:0]        sh_s;
  logic              sh_il;
  logic              sh_ir;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_amt, sh_q,
    output cmd_ready, sh_in, sh_s, sh_il, sh_ir,
    output busy, done, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_amt, sh_q,
    input  cmd_ready, sh_in, sh_s, sh_il, sh_ir,
    input  busy, done, err
  );
endinterface

// File: rtl/shift_sequencer.sv
// Sequencer turning load/shift/rotate commands into per-cycle
// select codes and fill bits for an 8-bit universal shift register.
module shift_sequencer #(
  parameter int DATA_W = 8,
  parameter int AMT_W  = 3
) (
  input  logic clk,
  input  logic reset,
  shift_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SRA  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;

  logic [1:0]        r_state;
  logic [2:0]        r_op;
  logic [DATA_W-1:0] r_data;
  logic [AMT_W-1:0]  r_cnt;
  logic              r_err;

  logic w_acc;
  logic w_legal;
  logic w_left;
  logic w_msb;
  logic w_lsb;

  assign bus.cmd_ready = (r_state == S_IDLE) & ~reset;
  assign w_acc   = bus.cmd_valid & bus.cmd_ready;
  assign w_legal = (bus.cmd_op < 3'b110);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_op   <= bus.cmd_op;
            r_data <= bus.cmd_data;
            r_cnt  <= bus.cmd_amt;
            r_err  <= ~w_legal;
            if (!w_legal)
              r_state <= S_DONE;
            else if (bus.cmd_op == OP_LOAD)
              r_state <= S_LOAD;
            else if (bus.cmd_amt == '0)
              r_state <= S_DONE;
            else
              r_state <= S_SHIFT;
          end
        end
        S_LOAD: r_state <= S_DONE;
        S_SHIFT: begin
          r_cnt <= r_cnt - AMT_W'(1);
          if (r_cnt == AMT_W'(1))
            r_state <= S_DONE;
        end
        S_DONE: r_state <= S_IDLE;
      endcase
    end
  end

  // fill bits come straight from the fed-back register output
  assign w_left = (r_op == OP_SLL) | (r_op == OP_ROL);
  assign w_msb  = bus.sh_q[DATA_W-1];
  assign w_lsb  = bus.sh_q[0];

  always_comb begin
    bus.sh_s  = 2'b00;
    bus.sh_il = 1'b0;
    bus.sh_ir = 1'b0;
    unique case (1'b1)
      (r_state == S_LOAD): bus.sh_s = 2'b01;
      (r_state == S_SHIFT): begin
        bus.sh_s  = w_left ? 2'b10 : 2'b11;
        bus.sh_ir = (r_op == OP_ROL) & w_msb;
        bus.sh_il = ((r_op == OP_SRA) & w_msb)
                  | ((r_op == OP_ROR) & w_lsb);
      end
      default: ;
    endcase
  end

  assign bus.sh_in = r_data;
  assign bus.busy  = (r_state != S_IDLE);
  assign bus.done  = (r_state == S_DONE);
  assign bus.err   = (r_state == S_DONE) & r_err;

endmodule
